ramen_order_feeder: RTL and testbench

- Upstream stage of the ramen shop controller. Queues customer orders from a valid/ready front end.
- Opens a selling session and serialises each order into the shop's 2-beat in_valid packet, then waits for the per-order response before sending the next order.
- Closes the session on request, captures the end-of-day totals and reports per-session success/reject counts.

---
 rtl/ramen_order_feeder.sv | 166 ++++++++++++++++
 tb/tb_ramen_order_feeder.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramen_order_feeder.sv
// Order feeder for the ramen shop: buffers customer orders and serialises each
// one into the shop's 2-beat packet, with session open/close and day-end reporting.
module ramen_order_feeder #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 7,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ord_valid,
  output logic             ord_ready,
  input  logic [1:0]       ord_type,
  input  logic             ord_portion,
  input  logic             close_req,
  output logic             selling,
  output logic             in_valid,
  output logic [1:0]       ramen_type,
  output logic             portion,
  input  logic             out_valid_order,
  input  logic             success,
  input  logic             out_valid_tot,
  input  logic [27:0]      sold_num,
  input  logic [14:0]      total_gain,
  output logic             report_valid,
  output logic [14:0]      report_gain,
  output logic [27:0]      report_sold,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] rej_cnt,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_OPEN  = 3'd1;
  localparam logic [2:0] S_BEAT0 = 3'd2;
  localparam logic [2:0] S_BEAT1 = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_CLOSE = 3'd6;

  logic [2:0]    state, state_nxt;
  logic [2:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [2:0]    head;
  logic          full, empty, push, pop, tmo;
  logic          close_pend;
  logic [TW-1:0] tcnt;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign ord_ready = !full;
  assign push      = ord_valid && !full;
  assign pop       = (state == S_BEAT1);
  assign head      = mem[rd_ptr[AW-1:0]];

  assign tmo = (tcnt == TW'(TIMEOUT - 1)) &&
               (((state == S_WAIT)  && !out_valid_order) ||
                ((state == S_CLOSE) && !out_valid_tot));

  // NOTE: every output gets a default first so no path through the case leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    selling    = 1'b0;
    in_valid   = 1'b0;
    ramen_type = 2'd0;
    portion    = 1'b0;
    case (state)
      S_OPEN:  selling = 1'b1;
      S_BEAT0: begin
        selling    = 1'b1;
        in_valid   = 1'b1;
        ramen_type = head[2:1];
      end
      S_BEAT1: begin
        selling  = 1'b1;
        in_valid = 1'b1;
        portion  = head[0];
      end
      S_WAIT:  selling = !(close_pend && empty);
      S_HOLD:  selling = 1'b1;
      default: selling = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_OPEN;
      S_OPEN:  state_nxt = S_BEAT0;
      S_BEAT0: state_nxt = S_BEAT1;
      S_BEAT1: state_nxt = S_WAIT;
      S_WAIT: begin
        if (out_valid_order) begin
          if (!selling)    state_nxt = S_CLOSE;
          else if (!empty) state_nxt = S_BEAT0;
          else             state_nxt = S_HOLD;
        end else if (tmo) begin
          state_nxt = S_IDLE;
        end
      end
      S_HOLD:  if (!empty) state_nxt = S_BEAT0;
      S_CLOSE: if (out_valid_tot || tmo) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      close_pend   <= 1'b0;
      tcnt         <= '0;
      ok_cnt       <= '0;
      rej_cnt      <= '0;
      err          <= 1'b0;
      report_valid <= 1'b0;
      report_gain  <= '0;
      report_sold  <= '0;
    end else begin
      state <= state_nxt;

      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      // A timeout discards everything queued before this cycle.
      if (tmo)      rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);

      if (state_nxt == S_IDLE)                  close_pend <= 1'b0;
      else if (close_req && (state != S_IDLE))  close_pend <= 1'b1;

      if ((state_nxt == S_WAIT  && state != S_WAIT) ||
          (state_nxt == S_CLOSE && state != S_CLOSE))
        tcnt <= '0;
      else if (state == S_WAIT || state == S_CLOSE)
        tcnt <= tcnt + TW'(1);

      if (state == S_IDLE && state_nxt == S_OPEN) begin
        ok_cnt  <= '0;
        rej_cnt <= '0;
      end else if (state == S_WAIT && out_valid_order) begin
        if (success && ok_cnt != '1)   ok_cnt  <= ok_cnt + CNT_W'(1);
        if (!success && rej_cnt != '1) rej_cnt <= rej_cnt + CNT_W'(1);
      end

      if (tmo) err <= 1'b1;

      report_valid <= (state == S_CLOSE) && out_valid_tot;
      if (state == S_CLOSE && out_valid_tot) begin
        report_gain <= total_gain;
        report_sold <= sold_num;
      end
    end
  end

  // NOTE: the order storage has no reset; the pointers alone define which
  // entries are live, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {ord_type, ord_portion};
  end

endmodule

// File: tb/tb_ramen_order_feeder.sv
// Directed bench for ramen_order_feeder: one task per scenario, hand-computed
// expectations, a hand-driven shop responder.
module tb_ramen_order_feeder;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 7;
  localparam int TIMEOUT = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ord_valid, ord_ready, ord_portion;
  logic [1:0]       ord_type;
  logic             close_req;
  logic             selling, in_valid, portion;
  logic [1:0]       ramen_type;
  logic             out_valid_order, success, out_valid_tot;
  logic [27:0]      sold_num, report_sold;
  logic [14:0]      total_gain, report_gain;
  logic             report_valid, err;
  logic [CNT_W-1:0] ok_cnt, rej_cnt;

  int vectors    = 0;
  int miscompares = 0;

  ramen_order_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_type(ord_type), .ord_portion(ord_portion),
    .close_req(close_req), .selling(selling), .in_valid(in_valid),
    .ramen_type(ramen_type), .portion(portion),
    .out_valid_order(out_valid_order), .success(success),
    .out_valid_tot(out_valid_tot), .sold_num(sold_num), .total_gain(total_gain),
    .report_valid(report_valid), .report_gain(report_gain), .report_sold(report_sold),
    .ok_cnt(ok_cnt), .rej_cnt(rej_cnt), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a packet, check both beats, then answer on the second
  // idle cycle so consecutive packets are separated by exactly two idle cycles.
  task automatic recv_packet(input logic [1:0] t, input logic p, input logic s,
                             input bit immediate, input logic sell_wait);
    int i = 0;
    while (in_valid !== 1'b1 && i < 40) begin
      step;
      i++;
    end
    vectors++;
    if (in_valid !== 1'b1 || (immediate && i != 0)) begin
      miscompares++;
      $display("FAIL pkt_start: in_valid=%b after %0d idle cycles, required in_valid=1 after %s",
               in_valid, i, immediate ? "0" : "<40");
    end
    vectors++;
    if ({in_valid, ramen_type, portion} !== {1'b1, t, 1'b0}) begin
      miscompares++;
      $display("FAIL beat0: {in_valid,type,portion}=%b required %b",
               {in_valid, ramen_type, portion}, {1'b1, t, 1'b0});
    end
    step;
    vectors++;
    if ({in_valid, ramen_type, portion} !== {1'b1, 2'b00, p}) begin
      miscompares++;
      $display("FAIL beat1: {in_valid,type,portion}=%b required %b",
               {in_valid, ramen_type, portion}, {1'b1, 2'b00, p});
    end
    step;
    vectors++;
    if (in_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL gap1: in_valid=%b required 0", in_valid);
    end
    step;
    vectors++;
    if ({in_valid, selling} !== {1'b0, sell_wait}) begin
      miscompares++;
      $display("FAIL gap2: {in_valid,selling}=%b required %b", {in_valid, selling}, {1'b0, sell_wait});
    end
    out_valid_order = 1'b1;
    success         = s;
    step;
    out_valid_order = 1'b0;
    success         = 1'b0;
  endtask

  task automatic close_day(input logic [14:0] gain, input logic [27:0] sold);
    vectors++;
    if (selling !== 1'b0) begin
      miscompares++;
      $display("FAIL close_sell: selling=%b required 0", selling);
    end
    out_valid_tot = 1'b1;
    total_gain    = gain;
    sold_num      = sold;
    step;
    out_valid_tot = 1'b0;
    total_gain    = '0;
    sold_num      = '0;
    vectors++;
    if ({report_valid, report_gain, report_sold} !== {1'b1, gain, sold}) begin
      miscompares++;
      $display("FAIL report: valid=%b gain=%0d sold=%h required valid=1 gain=%0d sold=%h",
               report_valid, report_gain, report_sold, gain, sold);
    end
    step;
    vectors++;
    if (report_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL report_pulse: report_valid=%b required 0 one cycle later", report_valid);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ord_valid = 1'b0; ord_type = '0; ord_portion = 1'b0; close_req = 1'b0;
    out_valid_order = 1'b0; success = 1'b0; out_valid_tot = 1'b0;
    sold_num = '0; total_gain = '0;
    step;
    step;
    vectors++;
    if ({selling, in_valid, ramen_type, portion, report_valid, report_gain, report_sold,
         ok_cnt, rej_cnt, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_vals: sel=%b iv=%b type=%0d por=%b rv=%b gain=%0d sold=%h ok=%0d rej=%0d err=%b required all 0",
               selling, in_valid, ramen_type, portion, report_valid, report_gain, report_sold,
               ok_cnt, rej_cnt, err);
    end
    vectors++;
    if (ord_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: ord_ready=%b required 1", ord_ready);
    end
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_single_order;
    ord_valid = 1'b1; ord_type = 2'd2; ord_portion = 1'b1;
    step;
    ord_valid = 1'b0;
    vectors++;
    if (selling !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_sell: selling=%b required 0", selling);
    end
    step;
    vectors++;
    if ({selling, in_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL open: {selling,in_valid}=%b required 10", {selling, in_valid});
    end
    step;
    vectors++;
    if ({selling, in_valid, ramen_type, portion} !== 5'b11_10_0) begin
      miscompares++;
      $display("FAIL first_beat0: {sel,iv,type,por}=%b required 11100", {selling, in_valid, ramen_type, portion});
    end
    step;
    vectors++;
    if ({selling, in_valid, ramen_type, portion} !== 5'b11_00_1) begin
      miscompares++;
      $display("FAIL first_beat1: {sel,iv,type,por}=%b required 11001", {selling, in_valid, ramen_type, portion});
    end
    step;
    vectors++;
    if ({selling, in_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL first_wait: {selling,in_valid}=%b required 10", {selling, in_valid});
    end
    step;
    close_req = 1'b1;
    step;
    close_req = 1'b0;
    vectors++;
    if (selling !== 1'b0) begin
      miscompares++;
      $display("FAIL close_wait_sell: selling=%b required 0", selling);
    end
    out_valid_order = 1'b1; success = 1'b1;
    step;
    out_valid_order = 1'b0; success = 1'b0;
    vectors++;
    if ({ok_cnt, rej_cnt} !== {7'd1, 7'd0}) begin
      miscompares++;
      $display("FAIL first_cnt: ok=%0d rej=%0d required ok=1 rej=0", ok_cnt, rej_cnt);
    end
    close_day(15'd200, 28'h0000080);
  endtask

  task automatic test_back_to_back;
    logic [2:0] tbl [4];
    tbl[0] = 3'b11_1; tbl[1] = 3'b00_1; tbl[2] = 3'b10_0; tbl[3] = 3'b01_1;
    ord_valid = 1'b1; ord_type = 2'd1; ord_portion = 1'b0;
    step;
    ord_valid = 1'b0;
    step;
    step;
    vectors++;
    if ({in_valid, ramen_type} !== 3'b1_01) begin
      miscompares++;
      $display("FAIL a_beat0: {in_valid,type}=%b required 101", {in_valid, ramen_type});
    end
    step;
    step;
    for (int k = 0; k < 4; k++) begin
      ord_valid = 1'b1; ord_type = tbl[k][2:1]; ord_portion = tbl[k][0];
      step;
    end
    ord_valid = 1'b0;
    vectors++;
    if (ord_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full: ord_ready=%b required 0 after 4 pushes", ord_ready);
    end
    vectors++;
    if (ok_cnt !== 7'd0) begin
      miscompares++;
      $display("FAIL new_session_clr: ok_cnt=%0d required 0", ok_cnt);
    end
    out_valid_order = 1'b1; success = 1'b1;
    step;
    out_valid_order = 1'b0; success = 1'b0;
    for (int k = 0; k < 4; k++)
      recv_packet(tbl[k][2:1], tbl[k][0], 1'b1, 1'b1, 1'b1);
    vectors++;
    if ({ord_ready, selling, in_valid, ok_cnt} !== {3'b110, 7'd5}) begin
      miscompares++;
      $display("FAIL hold: ready=%b sel=%b iv=%b ok=%0d required ready=1 sel=1 iv=0 ok=5",
               ord_ready, selling, in_valid, ok_cnt);
    end
  endtask

  task automatic test_close_in_hold;
    close_req = 1'b1;
    step;
    close_req = 1'b0;
    step; step; step;
    vectors++;
    if ({selling, in_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL hold_close_sell: {selling,in_valid}=%b required 10", {selling, in_valid});
    end
    ord_valid = 1'b1; ord_type = 2'd0; ord_portion = 1'b0;
    step;
    ord_valid = 1'b0;
    recv_packet(2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({selling, ok_cnt} !== {1'b0, 7'd6}) begin
      miscompares++;
      $display("FAIL hold_close_cnt: selling=%b ok=%0d required selling=0 ok=6", selling, ok_cnt);
    end
    close_day(15'd1234, 28'h0608080);
  endtask

  task automatic test_alternating;
    logic [3:0] tbl [6];
    // {type, portion, success}
    tbl[0] = 4'b11_0_1; tbl[1] = 4'b10_1_0; tbl[2] = 4'b01_1_1;
    tbl[3] = 4'b00_1_0; tbl[4] = 4'b11_1_1; tbl[5] = 4'b10_0_0;
    vectors++;
    if ({ok_cnt, rej_cnt} !== {7'd6, 7'd0}) begin
      miscompares++;
      $display("FAIL cnt_hold: ok=%0d rej=%0d required ok=6 rej=0 between sessions", ok_cnt, rej_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      ord_valid = 1'b1; ord_type = tbl[k][3:2]; ord_portion = tbl[k][1];
      step;
    end
    ord_valid = 1'b0;
    vectors++;
    if ({ok_cnt, rej_cnt} !== 14'd0) begin
      miscompares++;
      $display("FAIL cnt_clear: ok=%0d rej=%0d required 0 0", ok_cnt, rej_cnt);
    end
    for (int k = 0; k < 3; k++)
      recv_packet(tbl[k][3:2], tbl[k][1], tbl[k][0], 1'b1, 1'b1);
    for (int k = 3; k < 5; k++) begin
      ord_valid = 1'b1; ord_type = tbl[k][3:2]; ord_portion = tbl[k][1];
      step;
    end
    ord_valid = 1'b0;
    for (int k = 3; k < 5; k++)
      recv_packet(tbl[k][3:2], tbl[k][1], tbl[k][0], 1'b1, 1'b1);
    ord_valid = 1'b1; ord_type = tbl[5][3:2]; ord_portion = tbl[5][1];
    step;
    ord_valid = 1'b0;
    recv_packet(tbl[5][3:2], tbl[5][1], tbl[5][0], 1'b0, 1'b1);
    vectors++;
    if ({ok_cnt, rej_cnt} !== {7'd3, 7'd3}) begin
      miscompares++;
      $display("FAIL alt_cnt: ok=%0d rej=%0d required ok=3 rej=3", ok_cnt, rej_cnt);
    end
  endtask

  task automatic test_reset_mid_beat1;
    ord_valid = 1'b1; ord_type = 2'd1; ord_portion = 1'b1;
    step;
    ord_type = 2'd2; ord_portion = 1'b0;
    step;
    ord_valid = 1'b0;
    step;
    vectors++;
    if ({selling, in_valid, portion} !== 3'b111) begin
      miscompares++;
      $display("FAIL pre_rst_beat1: {sel,iv,por}=%b required 111", {selling, in_valid, portion});
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({selling, in_valid, ok_cnt, rej_cnt} !== '0) begin
      miscompares++;
      $display("FAIL async_rst: sel=%b iv=%b ok=%0d rej=%0d required all 0",
               selling, in_valid, ok_cnt, rej_cnt);
    end
    step;
    rst_n = 1'b1;
    step; step; step;
    vectors++;
    if ({selling, in_valid, ord_ready, ok_cnt, rej_cnt} !== {3'b001, 14'd0}) begin
      miscompares++;
      $display("FAIL post_rst: sel=%b iv=%b ready=%b ok=%0d rej=%0d required sel=0 iv=0 ready=1 ok=0 rej=0",
               selling, in_valid, ord_ready, ok_cnt, rej_cnt);
    end
  endtask

  task automatic test_timeout;
    ord_valid = 1'b1; ord_type = 2'd3; ord_portion = 1'b1;
    step;
    ord_valid = 1'b0;
    step; step; step; step;
    vectors++;
    if ({selling, in_valid, err} !== 3'b100) begin
      miscompares++;
      $display("FAIL tmo_wait0: {sel,iv,err}=%b required 100", {selling, in_valid, err});
    end
    ord_valid = 1'b1; ord_type = 2'd2; ord_portion = 1'b1;
    step;
    ord_valid = 1'b0;
    for (int k = 0; k < TIMEOUT - 2; k++) step;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_early: err=%b required 0 at cycle %0d of WAIT", err, TIMEOUT - 1);
    end
    step;
    vectors++;
    if ({err, selling, in_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL tmo_fire: {err,sel,iv}=%b required 100", {err, selling, in_valid});
    end
    step; step; step;
    vectors++;
    if ({err, selling, in_valid, ord_ready, report_valid} !== 5'b10010) begin
      miscompares++;
      $display("FAIL tmo_flush: {err,sel,iv,ready,rv}=%b required 10010", {err, selling, in_valid, ord_ready, report_valid});
    end
    out_valid_order = 1'b1; success = 1'b1;
    step;
    out_valid_order = 1'b0; success = 1'b0;
    vectors++;
    if ({ok_cnt, err} !== {7'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL idle_strobe: ok=%0d err=%b required ok=0 err=1", ok_cnt, err);
    end
  endtask

  initial begin
    test_reset;
    test_single_order;
    test_back_to_back;
    test_close_in_hold;
    test_alternating;
    test_reset_mid_beat1;
    test_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
